// File: rtl/ov7670_cfg_pkg.sv
// Shared encodings and constants for the OV7670 register-initialisation sequencer.
// States are one-hot so each bit maps directly onto a single phase of the walk.
package ov7670_cfg_pkg;

    typedef enum logic [5:0] {
        ST_PWRUP  = 6'b000001,
        ST_LOAD   = 6'b000010,
        ST_WRITE  = 6'b000100,
        ST_GAP    = 6'b001000,
        ST_SETTLE = 6'b010000,
        ST_DONE   = 6'b100000
    } cfg_state_e;

    localparam logic [7:0] SOFT_RST_ADDR = 8'h12;
    localparam logic [7:0] SOFT_RST_DATA = 8'h80;
    localparam logic [7:0] END_MARK      = 8'hFF;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Registered OV7670 init table: q = {addr, data}, one-cycle read latency.
// Indices past the populated entries read back as the end-of-table marker.
module ov7670_reg_rom (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  idx,
    output logic [15:0] q
);
    import ov7670_cfg_pkg::*;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (idx)
                8'd0:    q <= {SOFT_RST_ADDR, SOFT_RST_DATA};
                8'd1:    q <= 16'h1101;
                8'd2:    q <= 16'h1204;
                8'd3:    q <= 16'h40D0;
                default: q <= {END_MARK, END_MARK};
            endcase
        end
    end

endmodule

// File: rtl/ov7670_reg_cfg.sv
// Power-up register sequencer feeding the SCCB write master: walks the init table,
// one level-held write_en per entry, with settle/gap waits and a per-write timeout.
module ov7670_reg_cfg #(
    parameter int unsigned REG_NUM        = 76,
    parameter int unsigned PWRUP_CYCLES   = 150000,
    parameter int unsigned SETTLE_CYCLES  = 50000,
    parameter int unsigned GAP_CYCLES     = 200,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       start,
    input  logic       sccb_done,
    output logic       write_en,
    output logic [7:0] sccb_addr,
    output logic [7:0] sccb_data,
    output logic [7:0] cfg_idx,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_err
);
    import ov7670_cfg_pkg::*;

    localparam int unsigned MAX_WAIT = max_u(max_u(PWRUP_CYCLES, SETTLE_CYCLES),
                                             max_u(GAP_CYCLES, TIMEOUT_CYCLES));
    localparam int unsigned CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       REG_LAST     = 8'(REG_NUM - 1);

    cfg_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             we_n, err_n;
    logic [7:0]       addr_n, data_n, idx_n;
    logic [15:0]      rom_q;

    ov7670_reg_rom u_rom (
        .clk (sclk),
        .rst (rst),
        .idx (cfg_idx),
        .q   (rom_q)
    );

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state     <= ST_PWRUP;
            cnt       <= '0;
            write_en  <= 1'b0;
            sccb_addr <= '0;
            sccb_data <= '0;
            cfg_idx   <= '0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            write_en  <= we_n;
            sccb_addr <= addr_n;
            sccb_data <= data_n;
            cfg_idx   <= idx_n;
            cfg_err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        we_n    = write_en;
        addr_n  = sccb_addr;
        data_n  = sccb_data;
        idx_n   = cfg_idx;
        err_n   = cfg_err;

        unique case (state)
            ST_PWRUP: begin
                if (cnt == PWRUP_LAST) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                state_n = ST_WRITE;
            end
            ST_WRITE: begin
                // First WRITE cycle issues the request; the timeout window opens with write_en.
                if (!write_en) begin
                    cnt_n = '0;
                    if (rom_q[15:8] == END_MARK) begin
                        state_n = ST_DONE;
                    end else begin
                        we_n   = 1'b1;
                        addr_n = rom_q[15:8];
                        data_n = rom_q[7:0];
                    end
                end else if (sccb_done) begin
                    we_n    = 1'b0;
                    state_n = ST_GAP;
                end else if (cnt == TIMEOUT_LAST) begin
                    we_n    = 1'b0;
                    err_n   = 1'b1;
                    state_n = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    if (cfg_idx == REG_LAST) begin
                        state_n = ST_DONE;
                    end else if (cfg_idx == 8'd0) begin
                        state_n = ST_SETTLE;
                    end else begin
                        idx_n   = cfg_idx + 8'd1;
                        state_n = ST_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    idx_n   = 8'd1;
                    state_n = ST_LOAD;
                end
            end
            ST_DONE: begin
                we_n = 1'b0;
                if (start) begin
                    err_n   = 1'b0;
                    idx_n   = 8'd0;
                    state_n = ST_LOAD;
                end
            end
            default: begin
                we_n    = 1'b0;
                state_n = ST_PWRUP;
            end
        endcase

        if (state_n != state) cnt_n = '0;
    end

    assign cfg_done = (state == ST_DONE);
    assign cfg_busy = (state != ST_DONE);

endmodule

// File: tb/tb_ov7670_reg_cfg.sv
// Directed/randomised bench for ov7670_reg_cfg: an SCCB responder per DUT and a
// timing model derived from the table-walk rules predict every write and completion.
module tb_ov7670_reg_cfg;

    localparam int PWRUP   = 100;
    localparam int SETTLE  = 50;
    localparam int GAP     = 10;
    localparam int TIMEOUT = 500;
    localparam int RN0     = 4;
    localparam int RN1     = 6;

    logic       clk;
    logic       rst       [2];
    logic       start     [2];
    logic       sccb_done [2];
    logic       write_en  [2];
    logic [7:0] sccb_addr [2];
    logic [7:0] sccb_data [2];
    logic [7:0] cfg_idx   [2];
    logic       cfg_busy  [2];
    logic       cfg_done  [2];
    logic       cfg_err   [2];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int resp_lat [2];
    bit resp_silent [2];
    bit stray_en;

    ov7670_reg_cfg #(
        .REG_NUM(RN0), .PWRUP_CYCLES(PWRUP), .SETTLE_CYCLES(SETTLE),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut0 (
        .sclk(clk), .rst(rst[0]), .start(start[0]), .sccb_done(sccb_done[0]),
        .write_en(write_en[0]), .sccb_addr(sccb_addr[0]), .sccb_data(sccb_data[0]),
        .cfg_idx(cfg_idx[0]), .cfg_busy(cfg_busy[0]), .cfg_done(cfg_done[0]),
        .cfg_err(cfg_err[0])
    );

    ov7670_reg_cfg #(
        .REG_NUM(RN1), .PWRUP_CYCLES(PWRUP), .SETTLE_CYCLES(SETTLE),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut1 (
        .sclk(clk), .rst(rst[1]), .start(start[1]), .sccb_done(sccb_done[1]),
        .write_en(write_en[1]), .sccb_addr(sccb_addr[1]), .sccb_data(sccb_data[1]),
        .cfg_idx(cfg_idx[1]), .cfg_busy(cfg_busy[1]), .cfg_done(cfg_done[1]),
        .cfg_err(cfg_err[1])
    );

    // clock / cycle count
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // SCCB master model: completion pulse resp_lat cycles after write_en rises,
    // silent when asked, and random stray pulses while no request is pending.
    for (genvar g = 0; g < 2; g++) begin : g_resp
        initial begin
            int rc;
            bit we_q;
            rc = 0;
            we_q = 1'b0;
            sccb_done[g] = 1'b0;
            forever begin
                @(negedge clk);
                sccb_done[g] = 1'b0;
                if (write_en[g] === 1'b1) begin
                    rc = we_q ? rc + 1 : 1;
                    if (!resp_silent[g] && rc == resp_lat[g]) sccb_done[g] = 1'b1;
                end else if (stray_en && $urandom_range(0, 15) == 0) begin
                    sccb_done[g] = 1'b1;
                end
                we_q = (write_en[g] === 1'b1);
            end
        end
    end

    // reference model
    function automatic logic [15:0] ref_entry(input int i);
        case (i)
            0:       return 16'h1280;
            1:       return 16'h1101;
            2:       return 16'h1204;
            3:       return 16'h40D0;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic int reg_num(input int d);
        return (d == 0) ? RN0 : RN1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_reset(input int d, input string tag);
        chk($sformatf("%s_we", tag),   32'(write_en[d]),  0);
        chk($sformatf("%s_addr", tag), 32'(sccb_addr[d]), 0);
        chk($sformatf("%s_data", tag), 32'(sccb_data[d]), 0);
        chk($sformatf("%s_idx", tag),  32'(cfg_idx[d]),   0);
        chk($sformatf("%s_done", tag), 32'(cfg_done[d]),  0);
        chk($sformatf("%s_err", tag),  32'(cfg_err[d]),   0);
        chk($sformatf("%s_busy", tag), 32'(cfg_busy[d]),  1);
    endtask

    task automatic wait_rise(input int d, input int limit, output int t);
        while (write_en[d] !== 1'b1 && cyc < limit) @(negedge clk);
        t = cyc;
    endtask

    task automatic pulse_start(input int d, output int s);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        s = cyc;
        chk($sformatf("d%0d_start_done", d), 32'(cfg_done[d]), 0);
        chk($sformatf("d%0d_start_busy", d), 32'(cfg_busy[d]), 1);
        chk($sformatf("d%0d_start_err", d),  32'(cfg_err[d]),  0);
        chk($sformatf("d%0d_start_idx", d),  32'(cfg_idx[d]),  0);
    endtask

    // Walk the whole table on DUT d and compare against the model's timeline.
    // mode 0: 300-cycle answers; 1: random; 2: random with 500 (timeout tie) and 1.
    task automatic run_table(input int d, input int t_first, input int mute,
                             input int mode, input bit poke);
        int t_exp, t_rise, t_fall, lat, poke_at, bad_hold, bad_we, last;
        bit err_exp, hit_mark;
        logic [15:0] ent;
        t_exp = t_first;
        t_fall = 0;
        err_exp = 1'b0;
        hit_mark = 1'b0;
        last = reg_num(d) - 1;
        for (int i = 0; i < reg_num(d); i++) begin
            ent = ref_entry(i);
            if (ent[15:8] == 8'hFF) begin
                hit_mark = 1'b1;
                last = i;
                break;
            end
            case (mode)
                0:       lat = 300;
                1:       lat = $urandom_range(2, 450);
                default: lat = (i == 1) ? TIMEOUT : (i == 2) ? 1 : $urandom_range(2, 450);
            endcase
            resp_lat[d] = lat;
            resp_silent[d] = (i == mute);
            wait_rise(d, t_exp + 50, t_rise);
            chk($sformatf("d%0d_rise_cyc_%0d", d, i), t_rise, t_exp);
            chk($sformatf("d%0d_addr_%0d", d, i), 32'(sccb_addr[d]), 32'(ent[15:8]));
            chk($sformatf("d%0d_data_%0d", d, i), 32'(sccb_data[d]), 32'(ent[7:0]));
            chk($sformatf("d%0d_idx_%0d", d, i),  32'(cfg_idx[d]), i);
            chk($sformatf("d%0d_busy_%0d", d, i), 32'(cfg_busy[d]), 1);
            t_exp = t_rise + ((i == mute) ? TIMEOUT : lat);
            poke_at = poke ? $urandom_range(1, (i == mute) ? 400 : ((lat > 1) ? lat - 1 : 1)) : -1;
            bad_hold = 0;
            for (int k = 1; write_en[d] === 1'b1 && k < TIMEOUT + 50; k++) begin
                @(negedge clk);
                start[d] = 1'b0;
                if (write_en[d] === 1'b1) begin
                    if (sccb_addr[d] !== ent[15:8] || sccb_data[d] !== ent[7:0]) bad_hold++;
                    if (k == poke_at) start[d] = 1'b1;
                end
            end
            start[d] = 1'b0;
            t_fall = cyc;
            chk($sformatf("d%0d_hold_%0d", d, i), bad_hold, 0);
            chk($sformatf("d%0d_fall_cyc_%0d", d, i), t_fall, t_exp);
            if (i == mute) err_exp = 1'b1;
            chk($sformatf("d%0d_err_%0d", d, i), 32'(cfg_err[d]), 32'(err_exp));
            t_exp = t_fall + GAP + ((i == 0) ? SETTLE : 0) + 2;
        end
        // Table end: after the last gap, or two cycles after reloading onto the marker.
        if (!hit_mark) t_exp = t_fall + GAP;
        bad_we = 0;
        while (cfg_done[d] !== 1'b1 && cyc < t_exp + 50) begin
            @(negedge clk);
            if (write_en[d] !== 1'b0) bad_we++;
        end
        chk($sformatf("d%0d_done_cyc", d), cyc, t_exp);
        chk($sformatf("d%0d_extra_we", d), bad_we, 0);
        chk($sformatf("d%0d_done_busy", d), 32'(cfg_busy[d]), 0);
        chk($sformatf("d%0d_done_err", d), 32'(cfg_err[d]), 32'(err_exp));
        chk($sformatf("d%0d_done_idx", d), 32'(cfg_idx[d]), last);
    endtask

    initial begin
        int c, s, t;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        resp_lat[0] = 300;
        resp_lat[1] = 300;
        resp_silent[0] = 1'b0;
        resp_silent[1] = 1'b0;
        stray_en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset(0, "rst0");
        check_reset(1, "rst1");
        stray_en = 1'b1;

        // power-up run with fixed 300-cycle answers
        rst[0] = 1'b0;
        c = cyc;
        run_table(0, c + PWRUP + 2, -1, 0, 1'b0);

        // restart from DONE, entry 2 never answered, start pokes during WRITE
        pulse_start(0, s);
        run_table(0, s + 2, 2, 1, 1'b1);

        // restart clears the sticky error; timeout-tie and 1-cycle answers
        pulse_start(0, s);
        run_table(0, s + 2, -1, 2, 1'b1);

        // async reset in the middle of entry 1
        pulse_start(0, s);
        resp_silent[0] = 1'b0;
        resp_lat[0] = 300;
        wait_rise(0, s + 10, t);
        while (write_en[0] === 1'b1 && cyc < t + 400) @(negedge clk);
        wait_rise(0, cyc + 100, t);
        chk("rst_mid_idx", 32'(cfg_idx[0]), 1);
        repeat ($urandom_range(5, 200)) @(negedge clk);
        chk("rst_mid_we_before", 32'(write_en[0]), 1);
        #2 rst[0] = 1'b1;
        #1;
        check_reset(0, "rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        c = cyc;
        run_table(0, c + PWRUP + 2, -1, 1, 1'b0);

        // six-entry walk stops on the end-of-table marker after entry 3
        rst[1] = 1'b0;
        c = cyc;
        run_table(1, c + PWRUP + 2, -1, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ov7670_reg_cfg.md
Name: ov7670_reg_cfg

Overview:
Register-initialisation sequencer that sits directly upstream of the SCCB write master. After power-up it walks a fixed table of OV7670 register address/data pairs. For each pair it presents sccb_addr/sccb_data, holds write_en for one SCCB transaction, and waits for the master's completion pulse. It reports progress, completion and a sticky timeout error to the capture/top logic.

Parameters:
REG_NUM, 76, number of table entries walked (1..255); the last index visited is REG_NUM-1.
PWRUP_CYCLES, 150000, sclk cycles to wait after reset before the first write (3 ms at 50 MHz).
SETTLE_CYCLES, 50000, extra wait after the soft-reset entry (index 0).
GAP_CYCLES, 200, idle cycles between transactions with write_en low.
TIMEOUT_CYCLES, 100000, maximum wait for sccb_done per transaction.

Ports:
sclk  in  1  system clock, 50 MHz
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; re-runs the table, honoured only in DONE
sccb_done  in  1  one-cycle pulse from the SCCB master marking the end of a 3-phase write
write_en  out  1  transaction request to the SCCB master, level-held
sccb_addr  out  8  register address
sccb_data  out  8  register data
cfg_idx  out  8  table index currently being written
cfg_busy  out  1  sequencing in progress
cfg_done  out  1  table finished; held until start or rst
cfg_err  out  1  sticky; at least one transaction timed out

Behaviour:
- Reset values:
  - write_en=0, sccb_addr=0, sccb_data=0, cfg_idx=0, cfg_done=0, cfg_err=0, cfg_busy=1.
  - FSM enters PWRUP; all counters are 0.
- States (one-hot) are PWRUP, LOAD, WRITE, GAP, SETTLE, DONE.
- PWRUP: counts PWRUP_CYCLES cycles, then goes to LOAD.
- LOAD: presents cfg_idx to the ROM, which has a 1-cycle registered read. Next cycle the FSM enters WRITE.
- WRITE, entry:
  - sccb_addr/sccb_data are registered from the ROM output.
  - write_en=1.
  - write_en first goes high 2 cycles after LOAD entry, with addr/data valid in the same cycle.
- WRITE, hold: write_en, sccb_addr and sccb_data are held constant until exit.
- WRITE, exit on sccb_done: write_en=0 on the next edge; go to GAP.
- WRITE, timeout: if TIMEOUT_CYCLES elapse without sccb_done, set cfg_err=1, set write_en=0, go to GAP. The sequencer proceeds and does not retry.
- End-of-table marker: if the ROM returns address 8'hFF, no write is issued; the FSM goes straight to DONE. This is an early end-of-table.
- GAP: counts GAP_CYCLES cycles, then:
  - cfg_idx==REG_NUM-1 -> DONE.
  - cfg_idx==0 -> SETTLE.
  - otherwise cfg_idx+1 -> LOAD.
- SETTLE: counts SETTLE_CYCLES cycles, then cfg_idx=1 -> LOAD.
- DONE: cfg_done=1, cfg_busy=0, write_en=0.
- start in DONE:
  - cfg_done=0, cfg_err=0, cfg_idx=0, cfg_busy=1, go to LOAD.
  - PWRUP is not repeated.
- start in any other state is ignored.
- sccb_done outside WRITE is ignored.
- sccb_done arriving in the same cycle that the timeout expires counts as success; cfg_err is not set.
- A single shared wait counter is sized to clog2 of the largest cycle parameter. It clears on every state change and never wraps.
- rst asserted mid-transaction: write_en drops immediately (async) and the sequence restarts from PWRUP.

Decomposition:
- Package ov7670_cfg_pkg holds:
  - the state encoding constants;
  - SOFT_RST_ADDR=8'h12, SOFT_RST_DATA=8'h80;
  - END_MARK=8'hFF.
- Sub-module ov7670_reg_rom:
  - input idx[7:0], output q[15:0] = {addr,data}, registered case-statement table.
  - Entries 0..3 are {12,80},{11,01},{12,04},{40,D0}; out-of-range indices return {FF,FF}.

Test Plan:
- Parameters for all scenarios: PWRUP=100, SETTLE=50, GAP=10, TIMEOUT=500, REG_NUM=4. An SCCB model returns sccb_done 300 cycles after write_en rises.
- Reset release -> write_en rises at cycle 102 with sccb_addr=12, sccb_data=80. After 12/80, the next write_en rises only after 10+50 idle cycles.
- Full run -> writes 12/80, 11/01, 12/04, 40/D0 in order, each with cfg_idx matching. Then cfg_done=1, cfg_busy=0, cfg_err=0.
- Model never answers entry 2 -> write_en drops 500 cycles after rising, cfg_err=1, entry 3 is still written, and cfg_done=1 with cfg_err held.
- start pulse in DONE -> cfg_done=0 and cfg_err cleared. The first write_en rises 2 cycles later with 12/80 and no PWRUP wait. A start pulse during WRITE has no effect.
- rst pulsed mid-WRITE of entry 1 -> write_en=0 immediately and all outputs return to reset values. The first write after release occurs at cycle 102 with 12/80.
- REG_NUM=6 (entries 4-5 out of range) -> after 40/D0, the FF marker sends the FSM to DONE with no fifth write_en.
